fe_sniff_packer: RTL and testbench

- Upstream neighbour of the main register block: packs sniffed front-end events (data bytes, status bytes) into 18-bit timestamped FIFO words.
- Buffers those words in an on-chip FIFO.
- Presents fifo_data_o / fifo_status_o / fifo_empty_o to the register block, which pops words via fifo_read_i.
- Single clock domain (cwusb_clk).

---
 rtl/fe_sniff_packer_pkg.sv | 54 +++++
 rtl/fe_sniff_packer_fifo.sv | 71 +++++++
 rtl/fe_sniff_packer.sv | 156 +++++++++++++++
 tb/tb_fe_sniff_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fe_sniff_packer_pkg.sv
// Shared word layout, command codes, status bit indices and packer types.
package fe_sniff_packer_pkg;

    localparam int unsigned FE_FIFO_CMD_START   = 16;
    localparam int unsigned FE_FIFO_CMD_BIT_LEN = 2;
    localparam int unsigned FE_FIFO_DATA_START  = 0;
    localparam int unsigned FE_FIFO_DATA_LEN    = 16;
    localparam int unsigned FE_WORD_W           = FE_FIFO_CMD_BIT_LEN + FE_FIFO_DATA_LEN;
    localparam int unsigned FE_BYTE_W           = 8;
    localparam int unsigned FE_DELTA_W          = 16;
    localparam int unsigned FE_DROP_W           = 16;
    localparam int unsigned FE_STATUS_W         = 6;

    localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] FE_FIFO_CMD_DATA = 2'b00;
    localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] FE_FIFO_CMD_TIME = 2'b01;
    localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] FE_FIFO_CMD_STAT = 2'b10;
    localparam logic [FE_FIFO_CMD_BIT_LEN-1:0] FE_FIFO_CMD_STRM = 2'b11;

    localparam int unsigned FIFO_STAT_EMPTY       = 0;
    localparam int unsigned FIFO_STAT_CAPTURE     = 1;
    localparam int unsigned FIFO_STAT_ALMOST_FULL = 2;
    localparam int unsigned FIFO_STAT_FULL        = 3;
    localparam int unsigned FIFO_STAT_UNDERFLOW   = 4;
    localparam int unsigned FIFO_STAT_OVERFLOW    = 5;

    // Deltas at or above this need a separate TIME word.
    localparam int unsigned FE_DELTA_THRESHOLD = 256;

    typedef struct packed {
        logic [FE_FIFO_CMD_BIT_LEN-1:0] cmd;
        logic [FE_FIFO_DATA_LEN-1:0]    data;
    } fe_word_t;

    typedef struct packed {
        logic [FE_FIFO_CMD_BIT_LEN-1:0] cmd;
        logic [FE_BYTE_W-1:0]           payload;
    } fe_hold_t;

    typedef enum logic {
        ACCEPT    = 1'b0,
        EMIT_HOLD = 1'b1
    } pk_state_t;

    // Builds a DATA/STAT word from command, payload byte and 8-bit stamp.
    function automatic fe_word_t pack_event(input logic [FE_FIFO_CMD_BIT_LEN-1:0] cmd,
                                            input logic [FE_BYTE_W-1:0] payload,
                                            input logic [FE_BYTE_W-1:0] stamp);
        fe_word_t w;
        w.cmd  = cmd;
        w.data = {payload, stamp};
        return w;
    endfunction

endpackage

// File: rtl/fe_sniff_packer_fifo.sv
// Single-clock FIFO with registered read port and occupancy-derived flags.
module fe_sync_fifo
    import fe_sniff_packer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WIDTH      = FE_WORD_W,
    parameter int unsigned AF_MARGIN  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_c;
    logic                  pop_c;

    // A pop frees a slot, so a write while full still lands when paired with a read.
    assign pop_c       = rd_en & ~empty & ~flush;
    assign push_c      = wr_en & ~flush & (~full | pop_c);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (count >= CNT_W'(DEPTH - AF_MARGIN));
    assign empty       = (count == '0);

    // Storage array, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Registered read port; holds its value between pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (pop_c) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

endmodule

// File: rtl/fe_sniff_packer.sv
// Packs sniffed front-end events into timestamped 18-bit words and buffers them.
module fe_sniff_packer
    import fe_sniff_packer_pkg::*;
#(
    parameter int unsigned pDEPTH_LOG2         = 10,
    parameter int unsigned pALMOST_FULL_MARGIN = 16
) (
    input  logic                   cwusb_clk,
    input  logic                   reset_i,
    input  logic                   capture_en_i,
    input  logic                   in_valid_i,
    input  logic                   in_is_stat_i,
    input  logic [FE_BYTE_W-1:0]   in_byte_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    input  logic                   clear_flags_i,
    input  logic                   fifo_read_i,
    output logic [FE_WORD_W-1:0]   fifo_data_o,
    output logic [FE_STATUS_W-1:0] fifo_status_o,
    output logic                   fifo_empty_o,
    output logic [FE_DROP_W-1:0]   drop_count_o
);

    pk_state_t                state;
    pk_state_t                state_n;
    logic [FE_DELTA_W-1:0]    delta;
    fe_hold_t                 hold;
    logic                     ready_c;
    logic                     wr_en_c;
    fe_word_t                 wr_word_c;
    logic                     latch_hold_c;
    logic [FE_FIFO_CMD_BIT_LEN-1:0] ev_cmd_c;
    logic                     drop_evt_c;
    logic                     ovf_evt_c;
    logic                     udf_evt_c;
    logic                     overflow;
    logic                     underflow;
    logic                     fifo_full;
    logic                     fifo_almost_full;
    logic                     fifo_empty;
    logic [pDEPTH_LOG2:0]     unused_fifo_count;

    assign ev_cmd_c = in_is_stat_i ? FE_FIFO_CMD_STAT : FE_FIFO_CMD_DATA;

    // Next-state and write selection; a large delta costs one extra TIME word.
    always_comb begin
        state_n      = state;
        ready_c      = 1'b0;
        wr_en_c      = 1'b0;
        wr_word_c    = '0;
        latch_hold_c = 1'b0;
        case (state)
            ACCEPT: begin
                ready_c = capture_en_i;
                if (in_valid_i && capture_en_i) begin
                    wr_en_c = 1'b1;
                    if (delta < FE_DELTA_W'(FE_DELTA_THRESHOLD)) begin
                        wr_word_c = pack_event(ev_cmd_c, in_byte_i, delta[FE_BYTE_W-1:0]);
                    end else begin
                        wr_word_c    = '{cmd: FE_FIFO_CMD_TIME, data: delta};
                        latch_hold_c = 1'b1;
                        state_n      = EMIT_HOLD;
                    end
                end
            end
            EMIT_HOLD: begin
                wr_en_c   = 1'b1;
                wr_word_c = pack_event(hold.cmd, hold.payload, 8'h00);
                state_n   = ACCEPT;
            end
            default: state_n = ACCEPT;
        endcase
    end

    // State register.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i || flush_i) begin
            state <= ACCEPT;
        end else begin
            state <= state_n;
        end
    end

    // Event held back while its TIME word goes out first.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i || flush_i) begin
            hold <= '0;
        end else if (latch_hold_c) begin
            hold <= '{cmd: ev_cmd_c, payload: in_byte_i};
        end
    end

    // Inter-event delta: restarts on every write attempt, freezes with capture off.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i || flush_i) begin
            delta <= '0;
        end else if (wr_en_c) begin
            delta <= '0;
        end else if (capture_en_i && (delta != '1)) begin
            delta <= delta + FE_DELTA_W'(1);
        end
    end

    assign in_ready_o = ready_c & ~reset_i;
    assign drop_evt_c = in_valid_i & capture_en_i & ~in_ready_o;
    assign ovf_evt_c  = drop_evt_c | (wr_en_c & ~flush_i & fifo_full & ~fifo_read_i);
    assign udf_evt_c  = fifo_read_i & fifo_empty & ~flush_i;

    // Sticky error flags; a coincident event wins over a clear.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt_c | (overflow & ~clear_flags_i);
            underflow <= udf_evt_c | (underflow & ~clear_flags_i);
        end
    end

    // Saturating count of refused events.
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            drop_count_o <= '0;
        end else if (drop_evt_c) begin
            if (clear_flags_i) begin
                drop_count_o <= FE_DROP_W'(1);
            end else if (drop_count_o != '1) begin
                drop_count_o <= drop_count_o + FE_DROP_W'(1);
            end
        end else if (clear_flags_i) begin
            drop_count_o <= '0;
        end
    end

    fe_sync_fifo #(
        .DEPTH_LOG2 (pDEPTH_LOG2),
        .WIDTH      (FE_WORD_W),
        .AF_MARGIN  (pALMOST_FULL_MARGIN)
    ) u_fifo (
        .clk         (cwusb_clk),
        .reset       (reset_i),
        .flush       (flush_i),
        .wr_en       (wr_en_c),
        .wr_data     (wr_word_c),
        .rd_en       (fifo_read_i),
        .rd_data     (fifo_data_o),
        .count       (unused_fifo_count),
        .full        (fifo_full),
        .almost_full (fifo_almost_full),
        .empty       (fifo_empty)
    );

    assign fifo_empty_o  = fifo_empty;
    assign fifo_status_o = {overflow, underflow, fifo_full, fifo_almost_full, capture_en_i, fifo_empty};

endmodule

// File: tb/tb_fe_sniff_packer.sv
// Directed bench for fe_sniff_packer with hand-computed expected words.
module tb_fe_sniff_packer;
    import fe_sniff_packer_pkg::*;

    logic        cwusb_clk = 1'b0;
    logic        reset_i;
    logic        capture_en_i;
    logic        in_valid_i;
    logic        in_is_stat_i;
    logic [7:0]  in_byte_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        clear_flags_i;
    logic        fifo_read_i;
    logic [17:0] fifo_data_o;
    logic [5:0]  fifo_status_o;
    logic        fifo_empty_o;
    logic [15:0] drop_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    fe_sniff_packer dut (
        .cwusb_clk     (cwusb_clk),
        .reset_i       (reset_i),
        .capture_en_i  (capture_en_i),
        .in_valid_i    (in_valid_i),
        .in_is_stat_i  (in_is_stat_i),
        .in_byte_i     (in_byte_i),
        .in_ready_o    (in_ready_o),
        .flush_i       (flush_i),
        .clear_flags_i (clear_flags_i),
        .fifo_read_i   (fifo_read_i),
        .fifo_data_o   (fifo_data_o),
        .fifo_status_o (fifo_status_o),
        .fifo_empty_o  (fifo_empty_o),
        .drop_count_o  (drop_count_o)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge cwusb_clk);
            #1;
        end
    endtask

    task automatic pop_expect(input string tag, input logic [17:0] exp);
        fifo_read_i = 1'b1;
        tick();
        fifo_read_i = 1'b0;
        check(tag, 32'(fifo_data_o), 32'(exp));
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_flags_i = 1'b1;
        tick();
        clear_flags_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        capture_en_i  = 1'b1;
        in_valid_i    = 1'b0;
        in_is_stat_i  = 1'b0;
        in_byte_i     = 8'h00;
        flush_i       = 1'b0;
        clear_flags_i = 1'b0;
        fifo_read_i   = 1'b0;
        tick(2);

        // Reset values
        check("rst_data",   32'(fifo_data_o),   32'h0);
        check("rst_empty",  32'(fifo_empty_o),  32'h1);
        check("rst_status", 32'(fifo_status_o), 32'h03);
        check("rst_drop",   32'(drop_count_o),  32'h0);
        check("rst_ready",  32'(in_ready_o),    32'h0);
        check("rst_state",  32'(dut.state),     32'(ACCEPT));

        // Basic packing: byte at delta 3, stat at delta 0
        reset_i = 1'b0;
        tick(3);
        check("ready_accept", 32'(in_ready_o), 32'h1);
        in_valid_i = 1'b1; in_byte_i = 8'hA5; in_is_stat_i = 1'b0;
        tick();
        in_byte_i = 8'h42; in_is_stat_i = 1'b1;
        tick();
        in_valid_i = 1'b0; in_is_stat_i = 1'b0;
        check("basic_not_empty", 32'(fifo_empty_o), 32'h0);
        pop_expect("basic_word0", 18'h0A503);
        pop_expect("basic_word1", 18'h24200);
        check("basic_empty", 32'(fifo_empty_o), 32'h1);
        tick();
        check("basic_data_hold", 32'(fifo_data_o), 32'h24200);

        // Time insertion after 300 idle cycles, plus a refused byte in EMIT_HOLD
        pulse_flush();
        tick(300);
        in_valid_i = 1'b1; in_byte_i = 8'h11;
        tick();
        check("time_state_hold", 32'(dut.state), 32'(EMIT_HOLD));
        check("time_ready_hold", 32'(in_ready_o), 32'h0);
        in_byte_i = 8'h77;
        tick();
        in_valid_i = 1'b0;
        check("time_drop_count", 32'(drop_count_o), 32'h1);
        check("time_overflow", 32'(fifo_status_o[FIFO_STAT_OVERFLOW]), 32'h1);
        pop_expect("time_word", 18'h1012C);
        pop_expect("time_held_word", 18'h01100);
        pulse_clear();
        check("time_clear_status", 32'(fifo_status_o), 32'h03);
        check("time_clear_drop", 32'(drop_count_o), 32'h0);

        // Capture off: delta frozen, events ignored silently
        pulse_flush();
        tick(5);
        capture_en_i = 1'b0; in_valid_i = 1'b1; in_byte_i = 8'h99;
        tick(100);
        check("freeze_ready", 32'(in_ready_o), 32'h0);
        check("freeze_drop", 32'(drop_count_o), 32'h0);
        check("freeze_status", 32'(fifo_status_o), 32'h01);
        capture_en_i = 1'b1; in_byte_i = 8'h33;
        tick();
        in_valid_i = 1'b0;
        pop_expect("freeze_word", 18'h03305);

        // Underflow, sticky across flush, read-on-empty with simultaneous write
        fifo_read_i = 1'b1;
        tick();
        fifo_read_i = 1'b0;
        check("udf_flag", 32'(fifo_status_o[FIFO_STAT_UNDERFLOW]), 32'h1);
        check("udf_data_kept", 32'(fifo_data_o), 32'h03305);
        pulse_flush();
        check("udf_sticky_flush", 32'(fifo_status_o[FIFO_STAT_UNDERFLOW]), 32'h1);
        fifo_read_i = 1'b1; in_valid_i = 1'b1; in_is_stat_i = 1'b1; in_byte_i = 8'h5A;
        tick();
        fifo_read_i = 1'b0; in_valid_i = 1'b0; in_is_stat_i = 1'b0;
        check("udf_wr_not_empty", 32'(fifo_empty_o), 32'h0);
        check("udf_wr_data_kept", 32'(fifo_data_o), 32'h03305);
        pop_expect("udf_wr_word", 18'h25A00);
        pulse_clear();
        check("udf_clear_status", 32'(fifo_status_o), 32'h03);

        // Fill to depth, almost_full threshold, overflow on the next write
        pulse_flush();
        in_valid_i = 1'b1;
        for (int i = 0; i < 1007; i++) begin
            in_byte_i = 8'(i + 1);
            tick();
        end
        check("fill_1007_af", 32'(fifo_status_o[FIFO_STAT_ALMOST_FULL]), 32'h0);
        in_byte_i = 8'(1008);
        tick();
        check("fill_1008_af", 32'(fifo_status_o[FIFO_STAT_ALMOST_FULL]), 32'h1);
        check("fill_1008_full", 32'(fifo_status_o[FIFO_STAT_FULL]), 32'h0);
        for (int i = 1008; i < 1023; i++) begin
            in_byte_i = 8'(i + 1);
            tick();
        end
        check("fill_1023_full", 32'(fifo_status_o[FIFO_STAT_FULL]), 32'h0);
        in_byte_i = 8'(1024);
        tick();
        check("fill_1024_full", 32'(fifo_status_o[FIFO_STAT_FULL]), 32'h1);
        check("fill_1024_ovf", 32'(fifo_status_o[FIFO_STAT_OVERFLOW]), 32'h0);
        in_byte_i = 8'hEE;
        tick();
        in_valid_i = 1'b0;
        check("ovf_flag", 32'(fifo_status_o[FIFO_STAT_OVERFLOW]), 32'h1);
        check("ovf_count", 32'(dut.u_fifo.count), 32'd1024);
        check("ovf_no_drop", 32'(drop_count_o), 32'h0);
        pulse_clear();
        check("ovf_cleared", 32'(fifo_status_o[FIFO_STAT_OVERFLOW]), 32'h0);
        in_valid_i = 1'b1; fifo_read_i = 1'b1; in_byte_i = 8'hEE;
        tick();
        in_valid_i = 1'b0; fifo_read_i = 1'b0;
        check("rdwr_full_ovf", 32'(fifo_status_o[FIFO_STAT_OVERFLOW]), 32'h0);
        check("rdwr_full_data", 32'(fifo_data_o), 32'h00100);
        check("rdwr_full_count", 32'(dut.u_fifo.count), 32'd1024);

        // Delta saturation after 70000 idle cycles
        pulse_flush();
        tick(70000);
        in_valid_i = 1'b1; in_is_stat_i = 1'b1; in_byte_i = 8'hC3;
        tick();
        in_valid_i = 1'b0; in_is_stat_i = 1'b0;
        tick();
        pop_expect("sat_time_word", 18'h1FFFF);
        pop_expect("sat_held_word", 18'h2C300);

        // Flush during EMIT_HOLD drops the held word
        pulse_flush();
        tick(256);
        in_valid_i = 1'b1; in_byte_i = 8'h44;
        tick();
        in_valid_i = 1'b0;
        check("flush_in_hold", 32'(dut.state), 32'(EMIT_HOLD));
        pulse_flush();
        check("flush_empty", 32'(fifo_empty_o), 32'h1);
        check("flush_state", 32'(dut.state), 32'(ACCEPT));
        tick(2);
        check("flush_no_held", 32'(fifo_empty_o), 32'h1);

        // Reset during EMIT_HOLD
        pulse_flush();
        tick(256);
        in_valid_i = 1'b1; in_byte_i = 8'h55;
        tick();
        in_valid_i = 1'b0;
        check("reset_in_hold", 32'(dut.state), 32'(EMIT_HOLD));
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("reset_empty", 32'(fifo_empty_o), 32'h1);
        check("reset_state", 32'(dut.state), 32'(ACCEPT));
        check("reset_data", 32'(fifo_data_o), 32'h0);
        check("reset_status", 32'(fifo_status_o), 32'h03);
        tick(2);
        check("reset_no_held", 32'(fifo_empty_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
